// File: rtl/pre_if_pcgen_if.sv
// Fetch-side bundle of the pre-IF PC generator: back-end redirects, BTB response,
// and the fetch request/BTB lookup it drives.
interface pre_if_pcgen_if;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        btb_ret_en;
    logic        btb_taken;
    logic [31:0] btb_ret_pc;
    logic        fetch_ready;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_en;
    logic [31:0] fs_pc;
    logic        fs_pred_taken;

    modport master (
        input  ex_redirect, ex_target, br_redirect, br_target,
               btb_ret_en, btb_taken, btb_ret_pc, fetch_ready,
        output fetch_req, fetch_pc, fetch_en, fs_pc, fs_pred_taken
    );

    modport slave (
        output ex_redirect, ex_target, br_redirect, br_target,
               btb_ret_en, btb_taken, btb_ret_pc, fetch_ready,
        input  fetch_req, fetch_pc, fetch_en, fs_pc, fs_pred_taken
    );
endinterface

// File: rtl/pre_if_pcgen.sv
// Pre-IF next-PC generator: owns the fetch PC and merges the BTB prediction with
// exception and branch-mispredict redirects before the IF stage.
module pre_if_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic               clk,
    input  logic               reset,
    pre_if_pcgen_if.master     pc_bus
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] fs_pc_q;
    logic        pend_q;
    logic        run;
    logic        fire;
    logic        pred_hit;
    logic [31:0] next_pc;

    // The BTB answer only belongs to the PC fired last cycle; pend_q qualifies it.
    assign run      = (state_q == S_RUN) && !reset;
    assign fire     = run && pc_bus.fetch_ready;
    assign pred_hit = pend_q && pc_bus.btb_ret_en && pc_bus.btb_taken && !reset;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        next_pc = pc_q;
        if (pc_bus.ex_redirect) begin
            next_pc = pc_bus.ex_target;
        end else if (pc_bus.br_redirect) begin
            next_pc = pc_bus.br_target;
        end else if (pred_hit) begin
            next_pc = pc_bus.btb_ret_pc;
        end
        // A stalled cycle latches the chosen PC so redirects survive the stall.
        pc_d = fire ? (next_pc + 32'd4) : next_pc;
    end

    // NOTE: state is updated with non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            pc_q    <= RESET_PC;
            fs_pc_q <= RESET_PC;
            pend_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT:  state_q <= S_RUN;
                S_RUN:   state_q <= S_RUN;
                default: state_q <= S_INIT;
            endcase
            pc_q   <= pc_d;
            pend_q <= fire;
            if (fire) begin
                fs_pc_q <= next_pc;
            end
        end
    end

    assign pc_bus.fetch_req     = run;
    assign pc_bus.fetch_pc      = next_pc;
    assign pc_bus.fetch_en      = fire;
    assign pc_bus.fs_pc         = fs_pc_q;
    assign pc_bus.fs_pred_taken = pred_hit;

endmodule

// File: tb/tb_pre_if_pcgen.sv
// Directed bench for pre_if_pcgen: a table of per-cycle vectors plus hand-written
// reset and reset-during-stall sequences.
module tb_pre_if_pcgen;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pre_if_pcgen_if pc_bus ();

    pre_if_pcgen #(.RESET_PC(32'h1C00_0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_bus (pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex;
        logic [31:0] ext;
        logic        br;
        logic [31:0] brt;
        logic        btb_en;
        logic        btb_tk;
        logic [31:0] btb_pc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_en;
        logic [31:0] e_fs;
        logic        e_pt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic ex, input logic [31:0] ext, input logic br,
                       input logic [31:0] brt, input logic btb_en, input logic btb_tk,
                       input logic [31:0] btb_pc, input logic rdy, input logic e_req,
                       input logic [31:0] e_pc, input logic e_en, input logic [31:0] e_fs,
                       input logic e_pt);
        vec_t v;
        v = '{ex, ext, br, brt, btb_en, btb_tk, btb_pc, rdy, e_req, e_pc, e_en, e_fs, e_pt};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ex, input logic [31:0] ext, input logic br,
                         input logic [31:0] brt, input logic btb_en, input logic btb_tk,
                         input logic [31:0] btb_pc, input logic rdy);
        pc_bus.ex_redirect = ex;
        pc_bus.ex_target   = ext;
        pc_bus.br_redirect = br;
        pc_bus.br_target   = brt;
        pc_bus.btb_ret_en  = btb_en;
        pc_bus.btb_taken   = btb_tk;
        pc_bus.btb_ret_pc  = btb_pc;
        pc_bus.fetch_ready = rdy;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] pc,
                              input logic en, input logic [31:0] fs, input logic pt);
        check({tag, ".fetch_req"},     32'(pc_bus.fetch_req),     32'(req));
        check({tag, ".fetch_pc"},      pc_bus.fetch_pc,           pc);
        check({tag, ".fetch_en"},      32'(pc_bus.fetch_en),      32'(en));
        check({tag, ".fs_pc"},         pc_bus.fs_pc,              fs);
        check({tag, ".fs_pred_taken"}, 32'(pc_bus.fs_pred_taken), 32'(pt));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        //   ex  ext            br  brt            en   tk   ret            rdy  req  pc             en   fs             pt
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  0, 32'h1C000000, 0, 32'h1C000000, 0); // INIT
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000000, 1, 32'h1C000000, 0);
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000004, 1, 32'h1C000000, 0);
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000008, 1, 32'h1C000004, 0);
        add(0, 32'h0,          0, 32'h0,          1, 1, 32'h1C000100,   1,  1, 32'h1C000100, 1, 32'h1C000008, 1); // BTB taken
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000104, 1, 32'h1C000100, 0);
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000108, 1, 32'h1C000104, 0);
        add(0, 32'h0,          0, 32'h0,          1, 1, 32'h1C000100,   0,  1, 32'h1C000100, 0, 32'h1C000108, 1); // hit, stall
        add(0, 32'h0,          0, 32'h0,          1, 1, 32'h1C000300,   0,  1, 32'h1C000100, 0, 32'h1C000108, 0); // BTB ignored
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0,  1, 32'h1C000100, 0, 32'h1C000108, 0);
        add(0, 32'h0,          0, 32'h0,          1, 1, 32'h1C000500,   1,  1, 32'h1C000100, 1, 32'h1C000108, 0); // fires held PC
        add(1, 32'h1C008000,   1, 32'h1C000200,   1, 1, 32'h1C000400,   1,  1, 32'h1C008000, 1, 32'h1C000100, 1); // ex > br > pred
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C008004, 1, 32'h1C008000, 0);
        add(0, 32'h0,          1, 32'h1C000200,   1, 1, 32'h1C000400,   1,  1, 32'h1C000200, 1, 32'h1C008004, 1); // br > pred
        add(0, 32'h0,          0, 32'h0,          1, 0, 32'h1C000900,   1,  1, 32'h1C000204, 1, 32'h1C000200, 0); // not taken
        add(1, 32'h1C00A000,   1, 32'h1C000300,   0, 0, 32'h0,          1,  1, 32'h1C00A000, 1, 32'h1C000204, 0); // ex > br
        add(1, 32'hFFFFFFFC,   0, 32'h0,          0, 0, 32'h0,          0,  1, 32'hFFFFFFFC, 0, 32'h1C00A000, 0); // capture in stall
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'hFFFFFFFC, 1, 32'h1C00A000, 0);
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h00000000, 1, 32'hFFFFFFFC, 0); // wrap
        add(0, 32'h0,          1, 32'h1C000002,   0, 0, 32'h0,          1,  1, 32'h1C000002, 1, 32'h00000000, 0); // misaligned
        add(0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1,  1, 32'h1C000006, 1, 32'h1C000002, 0);

        // Reset held for two cycles: outputs quiet, fs_pc at RESET_PC afterwards.
        @(posedge clk);
        @(negedge clk);
        check_outs("reset", 1'b0, 32'h1C000000, 1'b0, 32'h1C000000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ex, vecs[i].ext, vecs[i].br, vecs[i].brt,
                  vecs[i].btb_en, vecs[i].btb_tk, vecs[i].btb_pc, vecs[i].rdy);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc,
                       vecs[i].e_en, vecs[i].e_fs, vecs[i].e_pt);
        end

        // Capture a branch target during a stall, then reset before it is fetched.
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 32'h1C000700, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check_outs("stall_br", 1'b1, 32'h1C000700, 1'b0, 32'h1C000006, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check_outs("stall_held", 1'b1, 32'h1C000700, 1'b0, 32'h1C000006, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.fetch_req", 32'(pc_bus.fetch_req), 32'd0);
        check("rst_mid.fetch_en",  32'(pc_bus.fetch_en),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        check_outs("rst_init", 1'b0, 32'h1C000000, 1'b0, 32'h1C000000, 1'b0);
        @(negedge clk);
        #1;
        check_outs("rst_first", 1'b1, 32'h1C000000, 1'b1, 32'h1C000000, 1'b0);
        @(negedge clk);
        #1;
        check_outs("rst_second", 1'b1, 32'h1C000004, 1'b1, 32'h1C000000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
